// File: rtl/id_stage.sv
// Decode stage of the 8-bit CPU: decodes fetch bytes, resolves operands from the
// register file with EXE forwarding and writeback bypass, and registers the bundle into EXE.
module id_stage #(
    parameter int NREG = 4,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          hold,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [1:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          fwd_en,
    input  logic [1:0]    fwd_addr,
    input  logic [DW-1:0] fwd_data,
    output logic [3:0]    ex_op,
    output logic [DW-1:0] ex_s1,
    output logic [DW-1:0] ex_s2,
    output logic [DW-1:0] ex_imm,
    output logic [1:0]    ex_dest,
    output logic          ex_wen,
    output logic          ex_valid,
    output logic          ill_instr
);

    typedef enum logic {DECODE = 1'b0, IMM = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ra_lat_q, ra_lat_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [3:0]    ex_op_q, ex_op_d;
    logic [DW-1:0] ex_s1_q, ex_s1_d;
    logic [DW-1:0] ex_s2_q, ex_s2_d;
    logic [DW-1:0] ex_imm_q, ex_imm_d;
    logic [1:0]    ex_dest_q, ex_dest_d;
    logic          ex_wen_q, ex_wen_d;
    logic          ex_valid_q, ex_valid_d;
    logic          ill_q, ill_d;

    logic          accept;
    logic [3:0]    op;
    logic [1:0]    ra, rb;
    logic [DW-1:0] s1_res, s2_res;

    assign op          = instr[7:4];
    assign ra          = instr[3:2];
    assign rb          = instr[1:0];
    assign instr_ready = !hold && !rst;
    assign accept      = instr_valid && instr_ready;

    // EXE result is newer than the writeback value, which is newer than the file.
    function automatic logic [DW-1:0] resolve(input logic [1:0] x, input logic [DW-1:0] rf_val);
        if (fwd_en && fwd_addr == x)     return fwd_data;
        else if (wb_en && wb_addr == x)  return wb_data;
        else                             return rf_val;
    endfunction

    assign s1_res = resolve(ra, rf_q[ra]);
    assign s2_res = resolve(rb, rf_q[rb]);

    always_comb begin
        state_d    = state_q;
        ra_lat_d   = ra_lat_q;
        ex_op_d    = ex_op_q;
        ex_s1_d    = ex_s1_q;
        ex_s2_d    = ex_s2_q;
        ex_imm_d   = ex_imm_q;
        ex_dest_d  = ex_dest_q;
        ex_wen_d   = ex_wen_q;
        ex_valid_d = ex_valid_q;
        ill_d      = ill_q;
        for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
        if (wb_en) rf_d[wb_addr] = wb_data;

        if (flush || (!hold && !accept)) begin
            // Bubble: the whole bundle is zeroed so EXE never sees stale fields.
            ex_op_d    = '0;
            ex_s1_d    = '0;
            ex_s2_d    = '0;
            ex_imm_d   = '0;
            ex_dest_d  = '0;
            ex_wen_d   = 1'b0;
            ex_valid_d = 1'b0;
            ill_d      = 1'b0;
            if (flush) state_d = DECODE;
        end else if (!hold) begin
            ex_op_d    = '0;
            ex_s1_d    = '0;
            ex_s2_d    = '0;
            ex_imm_d   = '0;
            ex_dest_d  = '0;
            ex_wen_d   = 1'b0;
            ex_valid_d = 1'b0;
            ill_d      = 1'b0;
            if (state_q == IMM) begin
                ex_op_d    = 4'hf;
                ex_imm_d   = instr;
                ex_dest_d  = ra_lat_q;
                ex_wen_d   = 1'b1;
                ex_valid_d = 1'b1;
                state_d    = DECODE;
            end else begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h6, 4'he: begin
                        ex_op_d    = op;
                        ex_s1_d    = s1_res;
                        ex_s2_d    = s2_res;
                        ex_dest_d  = ra;
                        ex_wen_d   = (op != 4'h6) && (op != 4'he);
                        ex_valid_d = 1'b1;
                    end
                    4'h9, 4'ha, 4'hb, 4'hc, 4'hd: ill_d = 1'b1;
                    4'hf: begin
                        ra_lat_d = ra;
                        state_d  = IMM;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DECODE;
            ra_lat_q   <= '0;
            ex_op_q    <= '0;
            ex_s1_q    <= '0;
            ex_s2_q    <= '0;
            ex_imm_q   <= '0;
            ex_dest_q  <= '0;
            ex_wen_q   <= 1'b0;
            ex_valid_q <= 1'b0;
            ill_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ra_lat_q   <= ra_lat_d;
            ex_op_q    <= ex_op_d;
            ex_s1_q    <= ex_s1_d;
            ex_s2_q    <= ex_s2_d;
            ex_imm_q   <= ex_imm_d;
            ex_dest_q  <= ex_dest_d;
            ex_wen_q   <= ex_wen_d;
            ex_valid_q <= ex_valid_d;
            ill_q      <= ill_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign ex_op     = ex_op_q;
    assign ex_s1     = ex_s1_q;
    assign ex_s2     = ex_s2_q;
    assign ex_imm    = ex_imm_q;
    assign ex_dest   = ex_dest_q;
    assign ex_wen    = ex_wen_q;
    assign ex_valid  = ex_valid_q;
    assign ill_instr = ill_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage of the 8-bit CPU. It sits directly upstream of the EXE-stage ALU.
- It accepts instruction bytes from fetch, decodes them, and reads a 4-entry 8-bit register file.
- It resolves operands through forwarding from EXE and bypass from writeback.
- It drives a registered op/s1/s2/imm bundle into EXE.
- LOADIMM is a two-byte instruction, handled by an internal state machine.

Parameters:
- NREG, 4, number of architectural registers (fixed at 4; 2-bit register fields).
- DW, 8, datapath width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- instr  in  8  instruction byte from fetch: op=[7:4], ra=[3:2], rb=[1:0].
- instr_valid  in  1  the instr byte is valid this cycle.
- instr_ready  out  1  the stage accepts the byte this cycle; equals !hold && !rst.
- hold  in  1  EXE back-pressure; freezes all stage state and outputs.
- flush  in  1  discards in-flight decode and issues a bubble.
- wb_en  in  1  writeback write enable.
- wb_addr  in  2  writeback register.
- wb_data  in  8  writeback data.
- fwd_en  in  1  the instruction now in EXE writes a register.
- fwd_addr  in  2  destination register of the EXE instruction.
- fwd_data  in  8  EXE ALU result.
- ex_op  out  4  opcode to the ALU.
- ex_s1  out  8  operand 1 (value of ra).
- ex_s2  out  8  operand 2 (value of rb).
- ex_imm  out  8  immediate (LOADIMM only; 0 otherwise).
- ex_dest  out  2  destination register (= ra).
- ex_wen  out  1  the issued instruction writes ex_dest.
- ex_valid  out  1  the bundle is a real instruction; 0 means a bubble.
- ill_instr  out  1  one-cycle pulse when a reserved opcode is decoded.

Behaviour:
- Reset (rst=1 at an edge):
  - All ex_* outputs go to 0, ill_instr goes to 0, state goes to DECODE.
  - R0..R3 are cleared to 0; a latched first byte is discarded.
  - rst overrides flush, hold and wb_en.
- Priority at each edge: rst > flush > hold > normal operation.
- hold=1: registers, state and outputs keep their values; no byte is accepted. wb_en writes to the register file still take effect.
- flush=1 (not rst):
  - State goes to DECODE, ex_valid goes to 0, ex_op to 0, ex_wen to 0.
  - A latched LOADIMM first byte is dropped.
  - The register-file write from wb_en still occurs.
- Accept: a byte is accepted when instr_valid && instr_ready.
- Operand resolution for register x:
  - if fwd_en && fwd_addr==x, use fwd_data;
  - else if wb_en && wb_addr==x, use wb_data;
  - else use R[x].
- State DECODE, byte accepted, registered next edge (latency 1):
  - op 1,2,3,4,5,7,8: ex_op=op, ex_s1=res(ra), ex_s2=res(rb), ex_imm=0, ex_dest=ra, ex_wen=1, ex_valid=1.
  - op 6 (OUT), op e (STORE): same fields, but ex_wen=0.
  - op 0 (NOP): bubble; ex_valid=0.
  - op 9..d (reserved): bubble; ill_instr=1 for exactly one cycle.
  - op f (LOADIMM): latch ra, go to IMM; the output issued this edge is a bubble.
- State IMM, byte accepted:
  - Issue ex_op=f, ex_imm=byte, ex_dest=latched ra, ex_wen=1, ex_valid=1, ex_s1=ex_s2=0.
  - Return to DECODE.
  - The immediate byte is never decoded as an opcode.
- No byte accepted (instr_valid=0) and no hold: output a bubble (ex_valid=0, ex_op=0, ex_wen=0); state unchanged.
- Register file:
  - Written at the edge when wb_en=1.
  - A write and a read of the same register in the same cycle returns wb_data (bypass above).
  - No overflow or width extension anywhere; all values are raw 8-bit.

Test Plan:
- Reset, then wb R2=0x35 and R1=0x0A; instr 0x19 (ADD ra=2, rb=1) -> next cycle ex_op=1, ex_s1=0x35, ex_s2=0x0A, ex_dest=2, ex_wen=1, ex_valid=1.
- instr 0xF4 then 0x80, back-to-back -> first output is a bubble; second has ex_op=f, ex_imm=0x80, ex_dest=1, ex_valid=1. Repeat with 0x80=0xF0 to confirm the second byte is not decoded as an opcode.
- Forwarding priority: R3=0x11, wb_en to R3 with 0x22, and fwd to R3 with 0x33 in the same cycle; instr 0x2F -> ex_s1=ex_s2=0x33. Same again without fwd -> 0x22.
- hold=1 for 3 cycles with instr_valid=1 -> instr_ready=0, outputs frozen, no byte consumed; after release the held byte issues once.
- flush asserted in IMM after 0xF8 -> next output is a bubble, state is DECODE, and the following 0x84 issues SHL with ex_dest=1 (not LOADIMM).
- instr 0xA0 -> ill_instr high for exactly 1 cycle, ex_valid=0. rst asserted mid-LOADIMM -> all outputs 0 and R0..R3 read back 0.
